audio_session_ctrl: RTL and testbench

Top-level session controller for the Lab3 audio recorder/player. It powers up the codec configuration, then turns the four user keys into start/pause/stop pulses for the I2S recorder and the DSP player. It also owns the SRAM-port select between those two masters and remembers the length of the last recording. It sits in Top between the key debouncers, the I2C initializer, the recorder and the player.

---
 rtl/audio_session_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_audio_session_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_session_ctrl.sv
// ============================================================================
// audio_session_ctrl : session FSM for the audio recorder/player (codec init,
//                      key commands, SRAM port select, recording length).
// Revision 1.0
// ============================================================================
`default_nettype none

module audio_session_ctrl #(
    parameter int              ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF,
    parameter int              SPEED_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_key_0,
    input  logic              i_key_1,
    input  logic              i_key_2,
    input  logic              i_key_3,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_init_start,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic              o_sram_sel,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_end_valid,
    output logic [SPEED_W-1:0] o_speed,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_REC        = 3'd2,
        S_REC_PAUSE  = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    localparam int CMD_REC_START  = 0;
    localparam int CMD_REC_PAUSE  = 1;
    localparam int CMD_REC_STOP   = 2;
    localparam int CMD_PLAY_START = 3;
    localparam int CMD_PLAY_PAUSE = 4;
    localparam int CMD_PLAY_STOP  = 5;

    state_t              state_q, state_d;
    logic [3:0]          key_d_q;
    logic                init_fired_q;
    logic                init_start_q;
    logic [5:0]          cmd_q, cmd_d;
    logic                sel_q, sel_d;
    logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
    logic                end_valid_q, end_valid_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;

    logic [3:0]          w_key;
    logic [3:0]          w_ev;
    logic                w_acted;

    assign w_key = {i_key_3, i_key_2, i_key_1, i_key_0};
    assign w_ev  = w_key & ~key_d_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_INIT;
            key_d_q      <= '0;
            init_fired_q <= 1'b0;
            init_start_q <= 1'b0;
            cmd_q        <= '0;
            sel_q        <= 1'b0;
            end_addr_q   <= '0;
            end_valid_q  <= 1'b0;
            speed_q      <= '0;
        end else begin
            state_q      <= state_d;
            key_d_q      <= w_key;
            init_fired_q <= 1'b1;
            init_start_q <= ~init_fired_q;
            cmd_q        <= cmd_d;
            sel_q        <= sel_d;
            end_addr_q   <= end_addr_d;
            end_valid_q  <= end_valid_d;
            speed_q      <= speed_d;
        end
    end

    // Each branch handles only the events applicable to its state, in priority
    // order; w_acted lets an unused key_3 event still step the speed.
    always_comb begin
        state_d     = state_q;
        cmd_d       = '0;
        sel_d       = sel_q;
        end_addr_d  = end_addr_q;
        end_valid_d = end_valid_q;
        speed_d     = speed_q;
        w_acted     = 1'b0;

        case (state_q)
            S_INIT: begin
                if (i_init_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_ev[0]) begin
                    state_d              = S_REC;
                    cmd_d[CMD_REC_START] = 1'b1;
                    sel_d                = 1'b0;
                    end_valid_d          = 1'b0;
                    w_acted              = 1'b1;
                end else if (w_ev[1] && end_valid_q) begin
                    state_d               = S_PLAY;
                    cmd_d[CMD_PLAY_START] = 1'b1;
                    sel_d                 = 1'b1;
                    w_acted               = 1'b1;
                end
            end
            S_REC, S_REC_PAUSE: begin
                if (w_ev[2] || (state_q == S_REC && i_rec_addr == MAX_ADDR)) begin
                    state_d             = S_IDLE;
                    cmd_d[CMD_REC_STOP] = 1'b1;
                    end_addr_d          = i_rec_addr;
                    end_valid_d         = 1'b1;
                    w_acted             = 1'b1;
                end else if (w_ev[0]) begin
                    if (state_q == S_REC) begin
                        state_d              = S_REC_PAUSE;
                        cmd_d[CMD_REC_PAUSE] = 1'b1;
                    end else begin
                        state_d              = S_REC;
                        cmd_d[CMD_REC_START] = 1'b1;
                    end
                    w_acted = 1'b1;
                end
            end
            S_PLAY, S_PLAY_PAUSE: begin
                if (w_ev[2] || (state_q == S_PLAY && i_play_addr >= end_addr_q)) begin
                    state_d              = S_IDLE;
                    cmd_d[CMD_PLAY_STOP] = 1'b1;
                    w_acted              = 1'b1;
                end else if (w_ev[1]) begin
                    if (state_q == S_PLAY) begin
                        state_d               = S_PLAY_PAUSE;
                        cmd_d[CMD_PLAY_PAUSE] = 1'b1;
                    end else begin
                        state_d               = S_PLAY;
                        cmd_d[CMD_PLAY_START] = 1'b1;
                    end
                    w_acted = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        if (state_q != S_INIT && !w_acted && w_ev[3]) begin
            speed_d = speed_q + SPEED_W'(1);
        end
    end

    assign o_init_start = init_start_q;
    assign o_rec_start  = cmd_q[CMD_REC_START];
    assign o_rec_pause  = cmd_q[CMD_REC_PAUSE];
    assign o_rec_stop   = cmd_q[CMD_REC_STOP];
    assign o_play_start = cmd_q[CMD_PLAY_START];
    assign o_play_pause = cmd_q[CMD_PLAY_PAUSE];
    assign o_play_stop  = cmd_q[CMD_PLAY_STOP];
    assign o_sram_sel   = sel_q;
    assign o_end_addr   = end_addr_q;
    assign o_end_valid  = end_valid_q;
    assign o_speed      = speed_q;
    assign o_state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_session_ctrl.sv
// ============================================================================
// tb_audio_session_ctrl : randomized bench for audio_session_ctrl against a
//                         session-level reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_audio_session_ctrl;

    localparam int          ADDR_W   = 20;
    localparam logic [19:0] MAX_ADDR = 20'hFFFFF;
    localparam int          SPEED_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_done = 1'b0;
    logic [3:0]        key = '0;
    logic [ADDR_W-1:0] rec_addr = '0;
    logic [ADDR_W-1:0] play_addr = '0;

    logic              init_start, rec_start, rec_pause, rec_stop;
    logic              play_start, play_pause, play_stop, sram_sel, end_valid;
    logic [ADDR_W-1:0] end_addr;
    logic [SPEED_W-1:0] speed;
    logic [2:0]        state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    audio_session_ctrl #(
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR),
        .SPEED_W  (SPEED_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_init_done  (init_done),
        .i_key_0      (key[0]),
        .i_key_1      (key[1]),
        .i_key_2      (key[2]),
        .i_key_3      (key[3]),
        .i_rec_addr   (rec_addr),
        .i_play_addr  (play_addr),
        .o_init_start (init_start),
        .o_rec_start  (rec_start),
        .o_rec_pause  (rec_pause),
        .o_rec_stop   (rec_stop),
        .o_play_start (play_start),
        .o_play_pause (play_pause),
        .o_play_stop  (play_stop),
        .o_sram_sel   (sram_sel),
        .o_end_addr   (end_addr),
        .o_end_valid  (end_valid),
        .o_speed      (speed),
        .o_state      (state)
    );

    // Session-level model: what the recorder/player is doing, not how.
    bit          m_first, m_ready, m_rec, m_play, m_paused, m_sel, m_valid;
    bit [3:0]    m_kprev;
    bit [19:0]   m_end;
    int          m_speed;
    bit [6:0]    m_cmd;   // {init, play_stop, play_pause, play_start, rec_stop, rec_pause, rec_start}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_first = 1; m_ready = 0; m_rec = 0; m_play = 0; m_paused = 0;
        m_sel = 0; m_valid = 0; m_kprev = '0; m_end = '0; m_speed = 0; m_cmd = '0;
    endtask

    task automatic model_edge();
        bit [3:0] e;
        bit acted;
        e = key & ~m_kprev;
        m_kprev = key;
        m_cmd = '0;
        m_cmd[6] = m_first;
        m_first = 0;
        acted = 0;
        if (!m_ready) begin
            if (init_done) m_ready = 1;
        end else begin
            if (m_rec) begin
                if (e[2] || (!m_paused && rec_addr == MAX_ADDR)) begin
                    m_rec = 0; m_cmd[2] = 1; m_end = rec_addr; m_valid = 1; acted = 1;
                end else if (e[0]) begin
                    m_paused = !m_paused;
                    if (m_paused) m_cmd[1] = 1; else m_cmd[0] = 1;
                    acted = 1;
                end
            end else if (m_play) begin
                if (e[2] || (!m_paused && play_addr >= m_end)) begin
                    m_play = 0; m_cmd[5] = 1; acted = 1;
                end else if (e[1]) begin
                    m_paused = !m_paused;
                    if (m_paused) m_cmd[4] = 1; else m_cmd[3] = 1;
                    acted = 1;
                end
            end else begin
                if (e[0]) begin
                    m_rec = 1; m_paused = 0; m_sel = 0; m_valid = 0; m_cmd[0] = 1; acted = 1;
                end else if (e[1] && m_valid) begin
                    m_play = 1; m_paused = 0; m_sel = 1; m_cmd[3] = 1; acted = 1;
                end
            end
            if (!acted && e[3]) m_speed = (m_speed + 1) % 8;
        end
    endtask

    function automatic int exp_state();
        if (!m_ready) return 0;
        if (m_rec)    return m_paused ? 3 : 2;
        if (m_play)   return m_paused ? 5 : 4;
        return 1;
    endfunction

    task automatic check_all();
        check("state", state, exp_state());
        check("cmds", {init_start, play_stop, play_pause, play_start, rec_stop, rec_pause, rec_start}, m_cmd);
        check("sram_sel", sram_sel, m_sel);
        check("end_valid", end_valid, m_valid);
        check("end_addr", end_addr, m_end);
        check("speed", speed, m_speed);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_outs"}, {init_start, rec_start, rec_pause, rec_stop, play_start,
                               play_pause, play_stop, sram_sel, end_valid}, 0);
        check({tag, "_addr"}, end_addr, 0);
        check({tag, "_speed"}, speed, 0);
    endtask

    task automatic randomize_inputs();
        int r;
        if ($urandom % 6 == 0)  key[0] = ~key[0];
        if ($urandom % 6 == 0)  key[1] = ~key[1];
        if ($urandom % 30 == 0) key[2] = ~key[2];
        if ($urandom % 5 == 0)  key[3] = ~key[3];
        init_done = 1'(($urandom % 2));
        rec_addr  = ($urandom % 50 == 0) ? MAX_ADDR : 20'($urandom_range(16, 20'hFFFFE));
        r = $urandom % 40;
        if (r == 0)      play_addr = m_end;
        else if (r == 1) play_addr = MAX_ADDR;
        else             play_addr = 20'($urandom_range(0, 15));
    endtask

    initial begin
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        init_done = 1'b1;
        step();
        init_done = 1'b0;
        step();

        // Directed speed wrap from idle: eight key_3 presses.
        for (int i = 0; i < 8; i++) begin
            key[3] = 1'b1; step();
            key[3] = 1'b0; step();
        end

        for (int i = 0; i < 4000; i++) begin
            randomize_inputs();
            step();
        end

        // Return to idle, enter record, then abort with an async reset.
        key = '0; rec_addr = 20'h00100; play_addr = '0; step();
        key = 4'b0100; step();
        key = '0; step();
        key = 4'b0001; step();
        key = '0; step();
        check("in_rec", state, 2);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        init_done = 1'b1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
